// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM states, frame marker,
// status codes and the instruction memory depth. The CPU bench reuses the
// status codes.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    localparam logic [7:0] PL_SYNC_BYTE = 8'hC0;
    localparam int         PL_MAX_WORDS = 4096;

    localparam logic [7:0] STATUS_IDLE    = 8'h00;
    localparam logic [7:0] STATUS_LOADING = 8'h01;
    localparam logic [7:0] STATUS_DONE    = 8'h02;
    localparam logic [7:0] STATUS_BAD_LEN = 8'h81;
    localparam logic [7:0] STATUS_BAD_CHK = 8'h82;

    // Running frame checksum: XOR of every payload byte.
    function automatic logic [7:0] chk_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader. Holds the CPU in reset, receives a framed
// image (sync, 16-bit word count, payload MSB-first, XOR checksum), writes
// the packed words into instruction RAM from address 0 and releases the CPU
// only when the checksum matches.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         MAX_WORDS = PL_MAX_WORDS,
    parameter logic [7:0] SYNC_BYTE = PL_SYNC_BYTE
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic [7:0]  inData,
    input  logic        inValid,
    output logic        inReady,
    output logic [11:0] imemAddress,
    output logic [31:0] imemData,
    output logic        imemWrEn,
    output logic        cpuNRst,
    output logic [7:0]  loaderStatus
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    state_t      state_r;
    logic        ready_r;
    logic [11:0] addr_r;
    logic [31:0] data_r;
    logic        wr_en_r;
    logic        cpu_nrst_r;
    logic [7:0]  status_r;
    logic [7:0]  len_hi_r;
    logic [15:0] len_r;
    logic [15:0] words_done_r;
    logic [1:0]  byte_cnt_r;
    logic [23:0] word_r;
    logic [7:0]  chk_r;

    logic        accept_s;
    logic        start_s;
    logic [15:0] len_in_s;

    assign accept_s = inValid && ready_r;
    assign len_in_s = {len_hi_r, inData};
    // A sync byte (re)starts a load only outside an active frame.
    assign start_s  = accept_s && (inData == SYNC_BYTE) &&
                      ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERROR));

    assign inReady      = ready_r;
    assign imemAddress  = addr_r;
    assign imemData     = data_r;
    assign imemWrEn     = wr_en_r;
    assign cpuNRst      = cpu_nrst_r;
    assign loaderStatus = status_r;

    // Loader FSM with word packer, checksum accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_r      <= ST_IDLE;
            ready_r      <= 1'b1;
            addr_r       <= 12'd0;
            data_r       <= 32'd0;
            wr_en_r      <= 1'b0;
            cpu_nrst_r   <= 1'b0;
            status_r     <= STATUS_IDLE;
            len_hi_r     <= 8'd0;
            len_r        <= 16'd0;
            words_done_r <= 16'd0;
            byte_cnt_r   <= 2'd0;
            word_r       <= 24'd0;
            chk_r        <= 8'd0;
        end else if (start_s) begin
            state_r      <= ST_LEN_HI;
            status_r     <= STATUS_LOADING;
            cpu_nrst_r   <= 1'b0;
            addr_r       <= 12'd0;
            chk_r        <= 8'd0;
            byte_cnt_r   <= 2'd0;
            words_done_r <= 16'd0;
        end else begin
            case (state_r)
                ST_LEN_HI: begin
                    if (accept_s) begin
                        len_hi_r <= inData;
                        state_r  <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (accept_s) begin
                        len_r <= len_in_s;
                        if ((len_in_s == 16'd0) || (len_in_s > MAX_LEN)) begin
                            state_r  <= ST_ERROR;
                            status_r <= STATUS_BAD_LEN;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (wr_en_r) begin
                        // Write cycle ends: advance to the next word slot.
                        wr_en_r      <= 1'b0;
                        ready_r      <= 1'b1;
                        addr_r       <= addr_r + 12'd1;
                        words_done_r <= words_done_r + 16'd1;
                        if ((words_done_r + 16'd1) == len_r) begin
                            state_r <= ST_CHECK;
                        end
                    end else if (accept_s) begin
                        chk_r      <= chk_next(chk_r, inData);
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            data_r  <= {word_r, inData};
                            wr_en_r <= 1'b1;
                            ready_r <= 1'b0;
                        end else begin
                            word_r <= {word_r[15:0], inData};
                        end
                    end
                end
                ST_CHECK: begin
                    if (accept_s) begin
                        if (inData == chk_r) begin
                            state_r    <= ST_DONE;
                            status_r   <= STATUS_DONE;
                            cpu_nrst_r <= 1'b1;
                        end else begin
                            state_r  <= ST_ERROR;
                            status_r <= STATUS_BAD_CHK;
                        end
                    end
                end
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    // Non-sync bytes are discarded here.
                    state_r <= state_r;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: frames are built at byte level,
// expected writes and final status come from a frame-level model.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        nRst;
    logic [7:0]  inData;
    logic        inValid;
    logic        inReady;
    logic [11:0] imemAddress;
    logic [31:0] imemData;
    logic        imemWrEn;
    logic        cpuNRst;
    logic [7:0]  loaderStatus;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk          (clk),
        .nRst         (nRst),
        .inData       (inData),
        .inValid      (inValid),
        .inReady      (inReady),
        .imemAddress  (imemAddress),
        .imemData     (imemData),
        .imemWrEn     (imemWrEn),
        .cpuNRst      (cpuNRst),
        .loaderStatus (loaderStatus)
    );

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] words_q[$];
    wr_t         mon_w;
    int          total = 0;
    int          bad = 0;
    int          low_cnt = 0;
    bit          mon_en = 1'b0;
    logic [7:0]  last_x;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Per-cycle monitor: writes match the model queue, one bubble per write,
    // CPU runs exactly when the status reports a good load.
    always @(negedge clk) begin
        if (mon_en) begin
            if (imemWrEn === 1'b1) begin
                chk("ready_in_write", {31'd0, inReady}, 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write actual=%h:%h required=none", imemAddress, imemData);
                end else begin
                    mon_w = exp_q.pop_front();
                    chk("wr_addr", {20'd0, imemAddress}, {20'd0, mon_w.a});
                    chk("wr_data", imemData, mon_w.d);
                end
            end else begin
                chk("ready_idle", {31'd0, inReady}, 32'd1);
            end
            chk("cpu_vs_status", {31'd0, cpuNRst}, {31'd0, (loaderStatus == 8'h02)});
            if (inReady === 1'b0) low_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int waited;
        bit acc;
        waited = 0;
        acc = 1'b0;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        inData  = b;
        inValid = 1'b1;
        while (!acc) begin
            acc = (inReady === 1'b1);
            @(negedge clk);
            waited++;
            if (!acc && waited > 20) begin
                total++;
                bad++;
                $display("FAIL accept_timeout actual=no_accept required=accept byte=%h", b);
                break;
            end
        end
        inValid = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_ready",  {31'd0, inReady}, 32'd1);
        chk("rst_wren",   {31'd0, imemWrEn}, 32'd0);
        chk("rst_addr",   {20'd0, imemAddress}, 32'd0);
        chk("rst_data",   imemData, 32'd0);
        chk("rst_cpu",    {31'd0, cpuNRst}, 32'd0);
        chk("rst_status", {24'd0, loaderStatus}, 32'd0);
    endtask

    // Sends a complete frame of n words taken from words_q. When literal_exp
    // is set the caller has already queued the expected writes.
    task automatic run_frame(input logic [15:0] n, input bit corrupt, input bit gaps, input bit literal_exp);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'd0;
        low_cnt = 0;
        send_byte(8'hC0, gaps);
        chk("status_loading", {24'd0, loaderStatus}, 32'h01);
        chk("cpu_held", {31'd0, cpuNRst}, 32'd0);
        send_byte(n[15:8], gaps);
        send_byte(n[7:0], gaps);
        if (n == 16'd0 || n > 16'd4096) begin
            chk("status_bad_len", {24'd0, loaderStatus}, 32'h81);
            chk("cpu_bad_len", {31'd0, cpuNRst}, 32'd0);
            chk("bad_len_low_cycles", low_cnt, 32'd0);
            return;
        end
        if (!literal_exp) begin
            for (int i = 0; i < int'(n); i++) exp_q.push_back('{a: 12'(i), d: words_q[i]});
        end
        for (int i = 0; i < int'(n); i++) begin
            for (int k = 0; k < 4; k++) begin
                b = words_q[i][31 - 8*k -: 8];
                x = x ^ b;
                send_byte(b, gaps);
            end
        end
        last_x = x;
        send_byte(corrupt ? ~x : x, gaps);
        chk("status_end", {24'd0, loaderStatus}, corrupt ? 32'h82 : 32'h02);
        chk("cpu_end", {31'd0, cpuNRst}, corrupt ? 32'd0 : 32'd1);
        chk("pending_writes", exp_q.size(), 32'd0);
        chk("ready_low_cycles", low_cnt, {16'd0, n});
    endtask

    task automatic rand_words(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back($urandom);
    endtask

    task automatic literal_frame1();
        words_q.delete();
        words_q.push_back(32'h11223344);
        words_q.push_back(32'hAABBCCDD);
        exp_q.push_back('{a: 12'd0, d: 32'h11223344});
        exp_q.push_back('{a: 12'd1, d: 32'hAABBCCDD});
    endtask

    initial begin
        nRst    = 1'b0;
        inData  = 8'h00;
        inValid = 1'b0;
        repeat (3) @(negedge clk);
        nRst = 1'b1;
        check_reset_vals();
        mon_en = 1'b1;

        // Idle discards non-sync bytes.
        send_byte(8'h00, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'hFF, 1'b0);
        chk("idle_discard", {24'd0, loaderStatus}, 32'h00);

        // Basic two-word frame.
        literal_frame1();
        run_frame(16'd2, 1'b0, 1'b0, 1'b1);
        chk("model_xor_frame1", {24'd0, last_x}, 32'h44);

        // Bad checksum, then a good random frame.
        literal_frame1();
        run_frame(16'd2, 1'b1, 1'b0, 1'b1);
        rand_words(3);
        run_frame(16'd3, 1'b0, 1'b0, 1'b0);

        // Length errors.
        run_frame(16'h0000, 1'b0, 1'b0, 1'b0);
        run_frame(16'h1001, 1'b0, 1'b0, 1'b0);

        // Frame 1 with random valid gaps.
        literal_frame1();
        run_frame(16'd2, 1'b0, 1'b1, 1'b1);

        // Restart from DONE with a word full of sync-valued data.
        words_q.delete();
        words_q.push_back(32'hC0C0C0C0);
        exp_q.push_back('{a: 12'd0, d: 32'hC0C0C0C0});
        run_frame(16'd1, 1'b0, 1'b0, 1'b1);
        chk("model_xor_c0", {24'd0, last_x}, 32'h00);

        // Reset in the middle of word 2 of a 3-word frame.
        rand_words(3);
        for (int i = 0; i < 3; i++) exp_q.push_back('{a: 12'(i), d: words_q[i]});
        send_byte(8'hC0, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        for (int k = 0; k < 4; k++) send_byte(words_q[0][31 - 8*k -: 8], 1'b0);
        send_byte(words_q[1][31:24], 1'b0);
        send_byte(words_q[1][23:16], 1'b0);
        nRst = 1'b0;
        @(negedge clk);
        check_reset_vals();
        chk("reset_drop_count", exp_q.size(), 32'd2);
        exp_q.delete();
        nRst = 1'b1;
        rand_words(3);
        run_frame(16'd3, 1'b0, 1'b1, 1'b0);

        // Random frames.
        for (int f = 0; f < 6; f++) begin
            rand_words($urandom_range(1, 8));
            run_frame(16'(words_q.size()), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0);
        end

        // Full-depth image: last write lands at 12'hFFF.
        rand_words(4096);
        run_frame(16'd4096, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader that writes the instruction memory read by the CPU's `instructionAddress`/`instructionIn` port. It holds the CPU in reset, receives a framed image over a valid/ready byte interface, packs it into 32-bit words, writes them from address 0 upward, verifies a checksum and then releases the CPU. It sits between the host link (UART receiver or debug bridge) and the instruction RAM write port.

## Interface
- `MAX_WORDS`, default 4096: instruction memory depth in words; matches the 12-bit instruction address.
- `SYNC_BYTE`, default 8'hC0: frame start marker.

Ports:
- `clk`  in  1  system clock
- `nRst`  in  1  reset; one clock, synchronous, active-low
- `inData`  in  8  stream byte
- `inValid`  in  1  `inData` valid
- `inReady`  out  1  loader accepts a byte; transfer when `inValid && inReady` at posedge
- `imemAddress`  out  12  instruction RAM write address
- `imemData`  out  32  instruction RAM write data
- `imemWrEn`  out  1  one-cycle write strobe
- `cpuNRst`  out  1  drives CPU `nRst`; low holds the CPU in reset
- `loaderStatus`  out  8  8'h00 idle, 8'h01 loading, 8'h02 done, 8'h81 bad length, 8'h82 checksum error

## Operation
- Frame: `SYNC_BYTE`, LEN_HI, LEN_LO (word count N, big-endian), N×4 payload bytes (each word MSB first), CHK. CHK is the XOR of all 4N payload bytes.
- States: IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR.
- IDLE: non-sync bytes are discarded. Sync byte -> LEN_HI; status 8'h01; checksum and address cleared.
- LEN_HI and LEN_LO latch N. If N == 0 or N > MAX_WORDS -> ERROR, status 8'h81.
- DATA: bytes shift into a 32-bit word register, with the first byte landing in [31:24]. After the 4th byte, `imemWrEn` pulses with the assembled word at the current address, then the address increments. After word N is written -> CHECK.
- CHECK: if the received byte equals the running XOR -> DONE, status 8'h02, `cpuNRst` goes high. Otherwise -> ERROR, status 8'h82.
- DONE and ERROR: a sync byte restarts the load. The restart drops `cpuNRst` low in the cycle after the sync byte is accepted, then proceeds as from IDLE. Other bytes are discarded.
- Sync bytes are not special inside LEN_HI through CHECK; 8'hC0 is valid data there.
- In ERROR, `cpuNRst` stays low, so the CPU never runs a bad image.

## Timing
- Reset values: state IDLE, `inReady` 1, `imemWrEn` 0, `imemAddress` 0, `imemData` 0, `cpuNRst` 0, `loaderStatus` 8'h00. The checksum and the byte counter within the word are cleared.
- All outputs are registered.
- `imemWrEn` is high for exactly one cycle. That cycle is the one after the 4th byte of a word is accepted. `imemAddress` and `imemData` are stable during it.
- `inReady` is 0 in the write cycle and 1 in all other cycles. This gives one bubble per word.
- Sustained throughput: 4 bytes per 5 cycles.
- `cpuNRst` rises in the cycle after a matching CHK is accepted.
- Address arithmetic is 12-bit. With N = 4096 the last write goes to 12'hFFF. The post-increment wrap to 0 is harmless because the state then leaves DATA.
- `inValid` low simply stalls. There is no timeout.
- `nRst` low mid-frame aborts the frame. The next cycle shows reset values, and words already written stay in RAM.

## Structure
- Shared package holds:
  - state enum
  - `SYNC_BYTE`
  - status codes 8'h00/01/02/81/82
  - `MAX_WORDS`
- The CPU bench reuses the status codes.
- Single module, with no sub-module. The word packer and the XOR accumulator are a few registers inside the FSM.

## Test plan
- Frame C0 00 02 11 22 33 44 AA BB CC DD then CHK = 11^22^33^44^AA^BB^CC^DD -> writes (0, 32'h11223344) and (1, 32'hAABBCCDD). Status goes to 02 and `cpuNRst` rises one cycle after CHK.
- Same frame with CHK inverted -> both words written, status 82, `cpuNRst` stays 0. A following correct frame reaches 02.
- Length 00 00 -> status 81 with no write. Length 10 01 (4097) -> status 81.
- Random `inValid` gaps, plus a check that no byte is accepted while `imemWrEn` = 1 -> same writes as the first scenario. Count `inReady` low cycles = N.
- From DONE, send C0 -> `cpuNRst` falls the next cycle and status is 01. Then reload 1 word 32'hC0C0C0C0 with CHK 00 -> status 02.
- Assert `nRst` during the 2nd word of a 3-word frame -> all outputs at reset values next cycle. A new full frame then loads correctly from address 0.
